// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths, reset values and the long-result buffer entry type.
package wb_arbiter_pkg;
  localparam int ADDR_W        = 5;
  localparam int DATA_W        = 32;
  localparam int WB_REG_NUM    = 32;
  localparam int WB_FIFO_DEPTH = 2;
  localparam logic [ADDR_W-1:0] ZERO_REG  = '0;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: EX, issue, long-unit and register-file write port signals of the write-back stage.
interface wb_arbiter_if import wb_arbiter_pkg::*; #(parameter int REG_NUM = WB_REG_NUM) ();
  logic              ex_we_i;
  logic [ADDR_W-1:0] ex_waddr_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic              iss_valid_i;
  logic [ADDR_W-1:0] iss_waddr_i;
  logic              lu_valid_i;
  logic [ADDR_W-1:0] lu_waddr_i;
  logic [DATA_W-1:0] lu_wdata_i;
  logic              lu_ready_o;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [DATA_W-1:0] wdata_o;
  logic [REG_NUM-1:0] busy_o;
  logic              err_o;
  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i, iss_valid_i, iss_waddr_i, lu_valid_i, lu_waddr_i, lu_wdata_i,
    input  lu_ready_o, we_o, waddr_o, wdata_o, busy_o, err_o
  );
  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i, iss_valid_i, iss_waddr_i, lu_valid_i, lu_waddr_i, lu_wdata_i,
    output lu_ready_o, we_o, waddr_o, wdata_o, busy_o, err_o
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO holding long-latency results that lost write-port arbitration.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          wr, rd;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rd    = pop && !empty;
    // A pop on a full FIFO frees the slot being written this edge.
    assign wr    = push && (!full || rd);
    assign dout  = mem[rp];
    always_ff @(posedge clk)
        if (wr) mem[wp] <= din;
    always_ff @(posedge clk)
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbitration of EX and long-latency results onto the single register write port,
// with a pending-write scoreboard for ID stalls and a sticky protocol-violation flag.
module wb_arbiter import wb_arbiter_pkg::*; #(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int REG_NUM    = WB_REG_NUM
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    wb_entry_t    head, lu_e, long_e;
    logic [$bits(wb_entry_t)-1:0] head_raw;
    logic         full, empty, ex_ok, iss_ok, lu_acc, lu_ok, direct, pop, push, long_wr, err_now;
    logic [CW-1:0] count;
    logic [REG_NUM-1:0] set, clr;
    assign lu_e    = '{addr: bus.lu_waddr_i, data: bus.lu_wdata_i};
    assign head    = head_raw;
    assign bus.lu_ready_o = count != CW'(FIFO_DEPTH);
    assign ex_ok   = bus.ex_we_i && bus.ex_waddr_i != ZERO_REG;
    assign iss_ok  = bus.iss_valid_i && bus.iss_waddr_i != ZERO_REG;
    assign lu_acc  = bus.lu_valid_i && bus.lu_ready_o;
    assign lu_ok   = lu_acc && bus.lu_waddr_i != ZERO_REG;
    assign direct  = !ex_ok && empty && lu_ok;
    assign pop     = !ex_ok && !empty;
    assign push    = lu_ok && !direct && !full;
    assign long_wr = pop || direct;
    assign long_e  = pop ? head : lu_e;
    assign clr     = long_wr ? REG_NUM'(1) << long_e.addr : '0;
    assign set     = iss_ok ? REG_NUM'(1) << bus.iss_waddr_i : '0;
    // A retirement in the same cycle frees the register for a legal re-issue.
    assign err_now = (iss_ok && bus.busy_o[bus.iss_waddr_i] && !clr[bus.iss_waddr_i])
                  || (ex_ok && bus.busy_o[bus.ex_waddr_i])
                  || (lu_acc && !bus.busy_o[bus.lu_waddr_i]);
    wb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(wb_entry_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (lu_e),
        .dout  (head_raw),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge clk)
        if (!rst) begin
            bus.we_o    <= 1'b0;
            bus.waddr_o <= ZERO_REG;
            bus.wdata_o <= ZERO_WORD;
            bus.busy_o  <= '0;
            bus.err_o   <= 1'b0;
        end else begin
            bus.we_o    <= ex_ok || long_wr;
            bus.waddr_o <= ex_ok ? bus.ex_waddr_i : long_wr ? long_e.addr : ZERO_REG;
            bus.wdata_o <= ex_ok ? bus.ex_wdata_i : long_wr ? long_e.data : ZERO_WORD;
            bus.busy_o  <= (bus.busy_o & ~clr) | set;
            bus.err_o   <= bus.err_o || err_now;
        end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vectors with hand-computed write-port, scoreboard and error expectations.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;
    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   bad  = 0;
    always #5 clk = ~clk;
    wb_arbiter_if bus ();
    wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ex_we_i = 0; bus.ex_waddr_i = 0; bus.ex_wdata_i = 0;
        bus.iss_valid_i = 0; bus.iss_waddr_i = 0;
        bus.lu_valid_i = 0; bus.lu_waddr_i = 0; bus.lu_wdata_i = 0;
    endtask

    task automatic ex(input logic [4:0] a, input logic [31:0] d);
        bus.ex_we_i = 1; bus.ex_waddr_i = a; bus.ex_wdata_i = d;
    endtask

    task automatic iss(input logic [4:0] a);
        bus.iss_valid_i = 1; bus.iss_waddr_i = a;
    endtask

    task automatic lu(input logic [4:0] a, input logic [31:0] d);
        bus.lu_valid_i = 1; bus.lu_waddr_i = a; bus.lu_wdata_i = d;
    endtask

    task automatic wport(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".we"}, 32'(bus.we_o), 32'(we));
        if (we) begin
            chk({tag, ".addr"}, 32'(bus.waddr_o), 32'(a));
            chk({tag, ".data"}, bus.wdata_o, d);
        end
    endtask

    initial begin
        rst = 0;
        ex(5'd4, 32'h1); iss(5'd6); lu(5'd6, 32'h2);
        tick(); tick();
        chk("rst.we", 32'(bus.we_o), 0);
        chk("rst.waddr", 32'(bus.waddr_o), 0);
        chk("rst.wdata", bus.wdata_o, 0);
        chk("rst.busy", bus.busy_o, 0);
        chk("rst.err", 32'(bus.err_o), 0);
        rst = 1; idle();
        chk("rst.rdy", 32'(bus.lu_ready_o), 1);

        ex(5'd5, 32'h1234); tick(); idle();
        wport("ex", 1, 5'd5, 32'h1234);
        chk("ex.busy", bus.busy_o, 0);
        tick();
        chk("ex.we_off", 32'(bus.we_o), 0);

        iss(5'd10); tick(); idle();
        chk("long.busy_set", bus.busy_o, 32'h400);
        tick(); tick();
        chk("long.busy_hold", bus.busy_o, 32'h400);
        lu(5'd10, 32'hDEAD);
        chk("long.rdy", 32'(bus.lu_ready_o), 1);
        tick(); idle();
        wport("long", 1, 5'd10, 32'hDEAD);
        chk("long.busy_clr", bus.busy_o, 0);
        chk("long.err", 32'(bus.err_o), 0);

        iss(5'd7); tick();
        iss(5'd8); tick(); idle();
        chk("col.busy", bus.busy_o, 32'h180);
        ex(5'd1, 32'h11); lu(5'd7, 32'h7777); tick();
        wport("col.c1", 1, 5'd1, 32'h11);
        chk("col.rdy1", 32'(bus.lu_ready_o), 1);
        ex(5'd2, 32'h22); lu(5'd8, 32'h8888); tick(); idle();
        wport("col.c2", 1, 5'd2, 32'h22);
        chk("col.rdy_full", 32'(bus.lu_ready_o), 0);
        ex(5'd3, 32'h33); tick();
        wport("col.c3", 1, 5'd3, 32'h33);
        ex(5'd4, 32'h44); tick(); idle();
        wport("col.c4", 1, 5'd4, 32'h44);
        chk("col.rdy_still", 32'(bus.lu_ready_o), 0);
        chk("col.busy_q", bus.busy_o, 32'h180);
        tick();
        wport("col.x7", 1, 5'd7, 32'h7777);
        chk("col.busy7", bus.busy_o, 32'h100);
        chk("col.rdy_pop", 32'(bus.lu_ready_o), 1);
        tick();
        wport("col.x8", 1, 5'd8, 32'h8888);
        chk("col.busy8", bus.busy_o, 0);
        tick();
        chk("col.drained", 32'(bus.we_o), 0);
        chk("col.err", 32'(bus.err_o), 0);

        iss(5'd9); tick(); idle();
        lu(5'd9, 32'h99); iss(5'd9); tick(); idle();
        wport("sc.x9", 1, 5'd9, 32'h99);
        chk("sc.busy9", bus.busy_o, 32'h200);
        chk("sc.err", 32'(bus.err_o), 0);
        lu(5'd9, 32'h999); tick(); idle();
        chk("sc.busy_clr", bus.busy_o, 0);

        iss(5'd3); tick();
        chk("v.err_pre", 32'(bus.err_o), 0);
        tick(); idle();
        chk("v.waw_err", 32'(bus.err_o), 1);
        chk("v.busy3", bus.busy_o, 32'h8);
        lu(5'd0, 32'hBAD0); tick(); idle();
        chk("v.x0_we", 32'(bus.we_o), 0);
        chk("v.x0_rdy", 32'(bus.lu_ready_o), 1);
        tick();
        chk("v.x0_none", 32'(bus.we_o), 0);
        chk("v.sticky", 32'(bus.err_o), 1);

        ex(5'd1, 32'h55); lu(5'd3, 32'h3333); tick(); idle();
        rst = 0; tick(); rst = 1;
        chk("mr.busy", bus.busy_o, 0);
        chk("mr.err", 32'(bus.err_o), 0);
        chk("mr.rdy", 32'(bus.lu_ready_o), 1);
        tick();
        chk("mr.flushed", 32'(bus.we_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end
endmodule
